// File: rtl/mips_mc_pkg.sv
// rtl/mips_mc_pkg.sv - shared opcodes, state encodings and control codes for the multicycle controller
//
// Purpose: constants and types used by the multicycle MIPS controller and its
// output decoder.
// Ports: none (package).

package mips_mc_pkg;

  // Supported instruction opcodes (IR[31:26])
  localparam logic [5:0] OP_RTYPE = 6'd0;
  localparam logic [5:0] OP_LW    = 6'd35;
  localparam logic [5:0] OP_SW    = 6'd43;
  localparam logic [5:0] OP_BEQ   = 6'd4;
  localparam logic [5:0] OP_J     = 6'd2;
  localparam logic [5:0] OP_ADDI  = 6'd8;

  // Controller states; encodings 13-15 are unused
  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_EXECUTE = 4'd6,
    S_RTYPEWB = 4'd7,
    S_BRANCH  = 4'd8,
    S_JUMP    = 4'd9,
    S_ADDIEX  = 4'd10,
    S_ADDIWB  = 4'd11,
    S_TRAP    = 4'd12
  } state_e;

  // ALUOp codes
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  // ALUSrcB codes
  localparam logic [1:0] SRCB_REG     = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

  // PCSource codes
  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  // Datapath control vector (PCEn is derived separately from Zero)
  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
  } ctrl_t;

  // An instruction retires on the edge that leaves its final state.
  // A store only completes once memory accepts it.
  function automatic logic retires(state_e s, logic mem_ready);
    logic r;
    case (s)
      S_MEMWB, S_RTYPEWB, S_BRANCH, S_JUMP, S_ADDIWB: r = 1'b1;
      S_MEMWR:                                        r = mem_ready;
      default:                                        r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/multicycle_control_if.sv
// rtl/multicycle_control_if.sv - controller <-> datapath control/status bundle
//
// Purpose: groups the opcode/status inputs and all control outputs of the
// multicycle controller.
// Modports:
//   master - controller side: reads opcode, Zero, MemReady; drives controls.
//   slave  - datapath side: drives opcode, Zero, MemReady; reads controls.

interface multicycle_control_if #(
  parameter int CNT_W = 32
);
  logic [5:0]       opcode;
  logic             Zero;
  logic             MemReady;
  logic             PCEn;
  logic             PCWrite;
  logic             PCWriteCond;
  logic             IorD;
  logic             MemRead;
  logic             MemWrite;
  logic             IRWrite;
  logic             MemtoReg;
  logic             RegDst;
  logic             RegWrite;
  logic             ALUSrcA;
  logic [1:0]       ALUSrcB;
  logic [1:0]       ALUOp;
  logic [1:0]       PCSource;
  logic             Illegal;
  logic [3:0]       State;
  logic [CNT_W-1:0] InstrCount;

  modport master (
    input  opcode, Zero, MemReady,
    output PCEn, PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite,
           MemtoReg, RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource,
           Illegal, State, InstrCount
  );

  modport slave (
    output opcode, Zero, MemReady,
    input  PCEn, PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite,
           MemtoReg, RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource,
           Illegal, State, InstrCount
  );
endinterface

// File: rtl/mc_output_decode.sv
// rtl/mc_output_decode.sv - combinational state to control-vector decode
//
// Purpose: Moore decode of the controller state into datapath controls.
// Ports:
//   rst       in  reset; forces every control to 0 while high
//   state     in  current controller state
//   mem_ready in  memory handshake; qualifies IRWrite/PCWrite in FETCH
//   ctrl      out control vector

module mc_output_decode
  import mips_mc_pkg::*;
(
  input  logic   rst,
  input  state_e state,
  input  logic   mem_ready,
  output ctrl_t  ctrl
);

  always_comb begin
    ctrl = '0;
    if (!rst) begin
      case (state)
        S_FETCH: begin
          ctrl.mem_read  = 1'b1;
          ctrl.iord      = 1'b0;
          ctrl.alu_src_a = 1'b0;
          ctrl.alu_src_b = SRCB_FOUR;
          ctrl.alu_op    = ALUOP_ADD;
          ctrl.pc_source = PCSRC_ALU;
          // IR and PC only advance in the cycle the fetch actually completes
          ctrl.ir_write  = mem_ready;
          ctrl.pc_write  = mem_ready;
        end
        S_DECODE: begin
          ctrl.alu_src_a = 1'b0;
          ctrl.alu_src_b = SRCB_IMM_SH2;
          ctrl.alu_op    = ALUOP_ADD;
        end
        S_MEMADR, S_ADDIEX: begin
          ctrl.alu_src_a = 1'b1;
          ctrl.alu_src_b = SRCB_IMM;
          ctrl.alu_op    = ALUOP_ADD;
        end
        S_MEMRD: begin
          ctrl.mem_read = 1'b1;
          ctrl.iord     = 1'b1;
        end
        S_MEMWB: begin
          ctrl.reg_dst    = 1'b0;
          ctrl.mem_to_reg = 1'b1;
          ctrl.reg_write  = 1'b1;
        end
        S_MEMWR: begin
          ctrl.mem_write = 1'b1;
          ctrl.iord      = 1'b1;
        end
        S_EXECUTE: begin
          ctrl.alu_src_a = 1'b1;
          ctrl.alu_src_b = SRCB_REG;
          ctrl.alu_op    = ALUOP_FUNCT;
        end
        S_RTYPEWB: begin
          ctrl.reg_dst    = 1'b1;
          ctrl.mem_to_reg = 1'b0;
          ctrl.reg_write  = 1'b1;
        end
        S_BRANCH: begin
          ctrl.alu_src_a     = 1'b1;
          ctrl.alu_src_b     = SRCB_REG;
          ctrl.alu_op        = ALUOP_SUB;
          ctrl.pc_write_cond = 1'b1;
          ctrl.pc_source     = PCSRC_ALUOUT;
        end
        S_JUMP: begin
          ctrl.pc_write  = 1'b1;
          ctrl.pc_source = PCSRC_JUMP;
        end
        S_ADDIWB: begin
          ctrl.reg_dst    = 1'b0;
          ctrl.mem_to_reg = 1'b0;
          ctrl.reg_write  = 1'b1;
        end
        default: ctrl = '0;  // TRAP and unused encodings
      endcase
    end
  end

endmodule

// File: rtl/multicycle_control.sv
// rtl/multicycle_control.sv - multicycle MIPS controller FSM with retire counter
//
// Purpose: sequences the shared-memory/shared-ALU datapath through fetch,
// decode, execute, memory and writeback; traps on unsupported opcodes and
// counts retired instructions.
// Ports:
//   CLK    in  system clock, posedge
//   RESET  in  asynchronous active-high reset
//   bus    master modport of multicycle_control_if (opcode/Zero/MemReady in,
//          datapath controls, Illegal, State, InstrCount out)

module multicycle_control
  import mips_mc_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic                 CLK,
  input  logic                 RESET,
  multicycle_control_if.master bus
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             illegal_q, illegal_d;
  ctrl_t            ctrl;

  // State register, retire counter and sticky illegal flag
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q   <= S_FETCH;
      cnt_q     <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      illegal_q <= illegal_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:  if (bus.MemReady) state_d = S_DECODE;
      S_DECODE: begin
        case (bus.opcode)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = S_EXECUTE;
          OP_BEQ:       state_d = S_BRANCH;
          OP_J:         state_d = S_JUMP;
          OP_ADDI:      state_d = S_ADDIEX;
          default:      state_d = S_TRAP;
        endcase
      end
      S_MEMADR:  state_d = (bus.opcode == OP_SW) ? S_MEMWR : S_MEMRD;
      S_MEMRD:   if (bus.MemReady) state_d = S_MEMWB;
      S_MEMWR:   if (bus.MemReady) state_d = S_FETCH;
      S_EXECUTE: state_d = S_RTYPEWB;
      S_ADDIEX:  state_d = S_ADDIWB;
      S_MEMWB, S_RTYPEWB, S_BRANCH, S_JUMP, S_ADDIWB: state_d = S_FETCH;
      S_TRAP:    state_d = S_TRAP;    // only RESET leaves the trap
      default:   state_d = S_FETCH;   // unused encodings recover
    endcase
  end

  // Counter wraps naturally modulo 2^CNT_W
  always_comb begin
    cnt_d     = retires(state_q, bus.MemReady) ? cnt_q + CNT_W'(1) : cnt_q;
    illegal_d = illegal_q | (state_d == S_TRAP);
  end

  // Output decode
  mc_output_decode u_output_decode (
    .rst       (RESET),
    .state     (state_q),
    .mem_ready (bus.MemReady),
    .ctrl      (ctrl)
  );

  assign bus.PCWrite     = ctrl.pc_write;
  assign bus.PCWriteCond = ctrl.pc_write_cond;
  assign bus.PCEn        = ctrl.pc_write | (ctrl.pc_write_cond & bus.Zero);
  assign bus.IorD        = ctrl.iord;
  assign bus.MemRead     = ctrl.mem_read;
  assign bus.MemWrite    = ctrl.mem_write;
  assign bus.IRWrite     = ctrl.ir_write;
  assign bus.MemtoReg    = ctrl.mem_to_reg;
  assign bus.RegDst      = ctrl.reg_dst;
  assign bus.RegWrite    = ctrl.reg_write;
  assign bus.ALUSrcA     = ctrl.alu_src_a;
  assign bus.ALUSrcB     = ctrl.alu_src_b;
  assign bus.ALUOp       = ctrl.alu_op;
  assign bus.PCSource    = ctrl.pc_source;
  assign bus.Illegal     = illegal_q;
  assign bus.State       = state_q;
  assign bus.InstrCount  = cnt_q;

endmodule

// File: tb/tb_multicycle_control.sv
// tb/tb_multicycle_control.sv - directed table-driven bench for multicycle_control

module tb_multicycle_control;

  localparam int CNT_W = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;

  multicycle_control_if #(.CNT_W(CNT_W)) bus ();

  multicycle_control #(.CNT_W(CNT_W)) dut (
    .CLK   (clk),
    .RESET (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // {PCEn,PCWrite,PCWriteCond,IorD,MemRead,MemWrite,IRWrite,MemtoReg,RegDst,RegWrite,ALUSrcA,ALUSrcB,ALUOp,PCSource}
  localparam logic [16:0] E_NONE   = 17'd0;
  localparam logic [16:0] E_FETCH  = {1'b1,1'b1,1'b0,1'b0,1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,2'b01,2'b00,2'b00};
  localparam logic [16:0] E_FSTALL = {1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b01,2'b00,2'b00};
  localparam logic [16:0] E_DECODE = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b11,2'b00,2'b00};
  localparam logic [16:0] E_MEMADR = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b10,2'b00,2'b00};
  localparam logic [16:0] E_MEMRD  = {1'b0,1'b0,1'b0,1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,2'b00};
  localparam logic [16:0] E_MEMWB  = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,1'b1,1'b0,2'b00,2'b00,2'b00};
  localparam logic [16:0] E_MEMWR  = {1'b0,1'b0,1'b0,1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,2'b00};
  localparam logic [16:0] E_EXEC   = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b00,2'b10,2'b00};
  localparam logic [16:0] E_RTWB   = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b1,1'b0,2'b00,2'b00,2'b00};
  localparam logic [16:0] E_BR1    = {1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b00,2'b01,2'b01};
  localparam logic [16:0] E_BR0    = {1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b00,2'b01,2'b01};
  localparam logic [16:0] E_JUMP   = {1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,2'b10};
  localparam logic [16:0] E_ADDIWB = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,2'b00,2'b00,2'b00};

  typedef struct {
    logic [5:0]  op;
    logic        zero;
    logic        ready;
    logic [3:0]  st;
    logic [16:0] ctl;
    logic        ill;
    logic [3:0]  cnt;
  } vec_t;

  vec_t vq[$];
  int   total = 0;
  int   bad   = 0;

  function automatic logic [16:0] act_ctl();
    return {bus.PCEn, bus.PCWrite, bus.PCWriteCond, bus.IorD, bus.MemRead, bus.MemWrite,
            bus.IRWrite, bus.MemtoReg, bus.RegDst, bus.RegWrite, bus.ALUSrcA,
            bus.ALUSrcB, bus.ALUOp, bus.PCSource};
  endfunction

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s[%0d] got=%h want=%h", name, idx, act, exp);
    end
  endtask

  task automatic add(input logic [5:0] op, input logic zero, input logic ready, input logic [3:0] st,
                     input logic [16:0] ctl, input logic ill, input logic [3:0] cnt);
    vec_t v;
    v.op = op; v.zero = zero; v.ready = ready; v.st = st; v.ctl = ctl; v.ill = ill; v.cnt = cnt;
    vq.push_back(v);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // R-type
    add(6'd0, 1'b0, 1'b1, 4'd0, E_FETCH, 1'b0, 4'd0);
    add(6'd0, 1'b0, 1'b1, 4'd1, E_DECODE, 1'b0, 4'd0);
    add(6'd0, 1'b0, 1'b1, 4'd6, E_EXEC, 1'b0, 4'd0);
    add(6'd0, 1'b0, 1'b1, 4'd7, E_RTWB, 1'b0, 4'd0);
    // lw
    add(6'd35, 1'b0, 1'b1, 4'd0, E_FETCH, 1'b0, 4'd1);
    add(6'd35, 1'b0, 1'b1, 4'd1, E_DECODE, 1'b0, 4'd1);
    add(6'd35, 1'b0, 1'b1, 4'd2, E_MEMADR, 1'b0, 4'd1);
    add(6'd35, 1'b0, 1'b1, 4'd3, E_MEMRD, 1'b0, 4'd1);
    add(6'd35, 1'b0, 1'b1, 4'd4, E_MEMWB, 1'b0, 4'd1);
    // sw with 3 stall cycles in MEMWR
    add(6'd43, 1'b0, 1'b1, 4'd0, E_FETCH, 1'b0, 4'd2);
    add(6'd43, 1'b0, 1'b1, 4'd1, E_DECODE, 1'b0, 4'd2);
    add(6'd43, 1'b0, 1'b1, 4'd2, E_MEMADR, 1'b0, 4'd2);
    add(6'd43, 1'b0, 1'b0, 4'd5, E_MEMWR, 1'b0, 4'd2);
    add(6'd43, 1'b0, 1'b0, 4'd5, E_MEMWR, 1'b0, 4'd2);
    add(6'd43, 1'b0, 1'b0, 4'd5, E_MEMWR, 1'b0, 4'd2);
    add(6'd43, 1'b0, 1'b1, 4'd5, E_MEMWR, 1'b0, 4'd2);
    // beq taken, then not taken
    add(6'd4, 1'b1, 1'b1, 4'd0, E_FETCH, 1'b0, 4'd3);
    add(6'd4, 1'b1, 1'b1, 4'd1, E_DECODE, 1'b0, 4'd3);
    add(6'd4, 1'b1, 1'b1, 4'd8, E_BR1, 1'b0, 4'd3);
    add(6'd4, 1'b0, 1'b1, 4'd0, E_FETCH, 1'b0, 4'd4);
    add(6'd4, 1'b0, 1'b1, 4'd1, E_DECODE, 1'b0, 4'd4);
    add(6'd4, 1'b0, 1'b1, 4'd8, E_BR0, 1'b0, 4'd4);
    // addi with 2-cycle fetch stall
    add(6'd8, 1'b0, 1'b0, 4'd0, E_FSTALL, 1'b0, 4'd5);
    add(6'd8, 1'b0, 1'b0, 4'd0, E_FSTALL, 1'b0, 4'd5);
    add(6'd8, 1'b0, 1'b1, 4'd0, E_FETCH, 1'b0, 4'd5);
    add(6'd8, 1'b0, 1'b1, 4'd1, E_DECODE, 1'b0, 4'd5);
    add(6'd8, 1'b0, 1'b1, 4'd10, E_MEMADR, 1'b0, 4'd5);
    add(6'd8, 1'b0, 1'b1, 4'd11, E_ADDIWB, 1'b0, 4'd5);
    // j
    add(6'd2, 1'b0, 1'b1, 4'd0, E_FETCH, 1'b0, 4'd6);
    add(6'd2, 1'b0, 1'b1, 4'd1, E_DECODE, 1'b0, 4'd6);
    add(6'd2, 1'b0, 1'b1, 4'd9, E_JUMP, 1'b0, 4'd6);
    // lw with one stall in MEMRD
    add(6'd35, 1'b0, 1'b1, 4'd0, E_FETCH, 1'b0, 4'd7);
    add(6'd35, 1'b0, 1'b1, 4'd1, E_DECODE, 1'b0, 4'd7);
    add(6'd35, 1'b0, 1'b1, 4'd2, E_MEMADR, 1'b0, 4'd7);
    add(6'd35, 1'b0, 1'b0, 4'd3, E_MEMRD, 1'b0, 4'd7);
    add(6'd35, 1'b0, 1'b1, 4'd3, E_MEMRD, 1'b0, 4'd7);
    add(6'd35, 1'b0, 1'b1, 4'd4, E_MEMWB, 1'b0, 4'd7);
    // illegal opcode
    add(6'd63, 1'b0, 1'b1, 4'd0, E_FETCH, 1'b0, 4'd8);
    add(6'd63, 1'b0, 1'b1, 4'd1, E_DECODE, 1'b0, 4'd8);
    add(6'd63, 1'b0, 1'b1, 4'd12, E_NONE, 1'b1, 4'd8);

    bus.opcode = 6'd0; bus.Zero = 1'b0; bus.MemReady = 1'b0;

    // Reset asserted mid-cycle; outputs must drop at once and hold through a clock edge
    #2 rst = 1'b1;
    #1;
    chk("rst_state", 0, bus.State, 4'd0);
    chk("rst_ctl", 0, act_ctl(), E_NONE);
    chk("rst_ill", 0, bus.Illegal, 1'b0);
    chk("rst_cnt", 0, bus.InstrCount, 4'd0);
    bus.MemReady = 1'b1;
    @(negedge clk);
    chk("rst_hold_state", 0, bus.State, 4'd0);
    chk("rst_hold_ctl", 0, act_ctl(), E_NONE);
    rst = 1'b0;

    for (int i = 0; i < vq.size(); i++) begin
      bus.opcode = vq[i].op; bus.Zero = vq[i].zero; bus.MemReady = vq[i].ready;
      #1;
      chk("vec_state", i, bus.State, vq[i].st);
      chk("vec_ctl", i, act_ctl(), vq[i].ctl);
      chk("vec_ill", i, bus.Illegal, vq[i].ill);
      chk("vec_cnt", i, bus.InstrCount, vq[i].cnt);
      @(negedge clk);
    end

    // TRAP holds with no strobes regardless of MemReady
    for (int i = 0; i < 10; i++) begin
      bus.opcode = 6'd0; bus.MemReady = i[0]; bus.Zero = 1'b1;
      #1;
      chk("trap_state", i, bus.State, 4'd12);
      chk("trap_ctl", i, act_ctl(), E_NONE);
      chk("trap_ill", i, bus.Illegal, 1'b1);
      chk("trap_cnt", i, bus.InstrCount, 4'd8);
      @(negedge clk);
    end

    // Reset clears the trap
    bus.MemReady = 1'b1; bus.Zero = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("trap_rst_state", 0, bus.State, 4'd0);
    chk("trap_rst_ill", 0, bus.Illegal, 1'b0);
    chk("trap_rst_cnt", 0, bus.InstrCount, 4'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("post_rst_ctl", 0, act_ctl(), E_FETCH);
    @(negedge clk);
    #1;
    chk("abort_decode", 0, bus.State, 4'd1);
    @(negedge clk);
    #1;
    chk("abort_exec_state", 0, bus.State, 4'd6);
    chk("abort_exec_ctl", 0, act_ctl(), E_EXEC);
    // Abort R-type in EXECUTE: controls drop immediately
    #2 rst = 1'b1;
    #1;
    chk("abort_state", 0, bus.State, 4'd0);
    chk("abort_ctl", 0, act_ctl(), E_NONE);
    chk("abort_cnt", 0, bus.InstrCount, 4'd0);
    @(negedge clk);
    rst = 1'b0;

    // 16 jumps wrap the 4-bit counter back to 0
    for (int k = 0; k < 16; k++) begin
      bus.opcode = 6'd2; bus.MemReady = 1'b1;
      #1;
      chk("wrap_fetch", k, bus.State, 4'd0);
      chk("wrap_cnt", k, bus.InstrCount, k[3:0]);
      @(negedge clk);
      #1;
      chk("wrap_decode", k, bus.State, 4'd1);
      @(negedge clk);
      #1;
      chk("wrap_jump", k, bus.State, 4'd9);
      @(negedge clk);
    end
    #1;
    chk("wrap_final_cnt", 0, bus.InstrCount, 4'd0);
    chk("wrap_final_state", 0, bus.State, 4'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Moore-style multicycle controller that sequences the shared single-memory / single-ALU MIPS datapath through FETCH, DECODE, EXECUTE, MEMORY and WRITEBACK.
- Replaces the combinational opcode decoder for the multicycle build.
- Drives the PC, IR, register-file, mux-select and ALUOp controls, and stalls on a memory-ready handshake.
- Flags illegal opcodes and counts retired instructions.

Parameters:
- CNT_W, 32, width of the retired-instruction counter InstrCount.

Ports:
- CLK  in  1  system clock; all state changes on posedge.
- RESET  in  1  asynchronous, active-high reset.
- opcode  in  6  IR[31:26]; sampled in DECODE and in states that branch on opcode.
- Zero  in  1  ALU zero flag, valid in BRANCH.
- MemReady  in  1  memory completes the current access this cycle.
- PCEn  out  1  PC load enable = PCWrite | (PCWriteCond & Zero).
- PCWrite, PCWriteCond  out  1  each  unconditional / conditional PC write.
- IorD  out  1  memory address select; 0 = PC, 1 = ALUOut.
- MemRead, MemWrite  out  1  each  memory strobes.
- IRWrite  out  1  instruction register load.
- MemtoReg  out  1  register write-data select; 1 = memory data register, 0 = ALUOut.
- RegDst  out  1  write-register select; 1 = rd, 0 = rt.
- RegWrite  out  1  register-file write.
- ALUSrcA  out  1  ALU A select; 0 = PC, 1 = A reg.
- ALUSrcB  out  2  ALU B select; 00 = B reg, 01 = 4, 10 = sign-ext imm, 11 = sign-ext imm << 2.
- ALUOp  out  2  00 = add, 01 = sub, 10 = funct-decoded.
- PCSource  out  2  00 = ALU result, 01 = ALUOut, 10 = jump target.
- Illegal  out  1  sticky; unsupported opcode decoded.
- State  out  4  current state encoding, for debug.
- InstrCount  out  CNT_W  retired instructions.

Behaviour:
- Reset:
  - RESET high asynchronously forces State = FETCH, InstrCount = 0, Illegal = 0.
  - While RESET is high, every control output is forced to 0.
- Supported opcodes: 0 R-type, 35 lw, 43 sw, 4 beq, 2 j, 8 addi.
- States, their asserted outputs (all others 0) and transitions:
  - FETCH (0): MemRead, IorD = 0, ALUSrcA = 0, ALUSrcB = 01, ALUOp = 00, PCSource = 00. IRWrite and PCWrite assert only when MemReady = 1. If MemReady = 0, stay in FETCH; otherwise go to DECODE.
  - DECODE (1): ALUSrcA = 0, ALUSrcB = 11, ALUOp = 00. Next state by opcode: lw/sw -> MEMADR, R -> EXECUTE, beq -> BRANCH, j -> JUMP, addi -> ADDIEX, other -> TRAP.
  - MEMADR (2): ALUSrcA = 1, ALUSrcB = 10, ALUOp = 00. lw -> MEMRD, sw -> MEMWR.
  - MEMRD (3): MemRead, IorD = 1. Wait while MemReady = 0, then go to MEMWB.
  - MEMWB (4): RegDst = 0, MemtoReg = 1, RegWrite. Next FETCH.
  - MEMWR (5): MemWrite, IorD = 1. Wait while MemReady = 0, then go to FETCH.
  - EXECUTE (6): ALUSrcA = 1, ALUSrcB = 00, ALUOp = 10. Next RTYPEWB.
  - RTYPEWB (7): RegDst = 1, MemtoReg = 0, RegWrite. Next FETCH.
  - BRANCH (8): ALUSrcA = 1, ALUSrcB = 00, ALUOp = 01, PCWriteCond, PCSource = 01. Next FETCH.
  - JUMP (9): PCWrite, PCSource = 10. Next FETCH.
  - ADDIEX (10): ALUSrcA = 1, ALUSrcB = 10, ALUOp = 00. Next ADDIWB.
  - ADDIWB (11): RegDst = 0, MemtoReg = 0, RegWrite. Next FETCH.
  - TRAP (12): Illegal = 1, all strobes 0. Remains in TRAP until RESET; no further fetch.
- Unused encodings 13-15 return to FETCH on the next clock, with no strobes asserted.
- Latency in cycles, assuming MemReady = 1 throughout: R = 4, lw = 5, sw = 4, beq = 3, j = 3, addi = 4. Each MemReady = 0 cycle adds 1.
- Retire: InstrCount increments by 1 on the clock edge leaving MEMWB, RTYPEWB, BRANCH, JUMP, ADDIWB, or leaving MEMWR with MemReady = 1. It wraps modulo 2^CNT_W.
- PCEn is combinational from the state outputs and Zero.
- RESET mid-instruction aborts it: no retire, outputs drop to 0 immediately.
- MemReady is ignored outside FETCH, MEMRD and MEMWR.

Decomposition:
- Package mips_mc_pkg holds:
  - opcode constants OP_RTYPE = 0, OP_LW = 35, OP_SW = 43, OP_BEQ = 4, OP_J = 2, OP_ADDI = 8;
  - the 4-bit state encodings;
  - ALUOp, ALUSrcB and PCSource code constants.
- Sub-module mc_output_decode: purely combinational state -> control-vector decode, gated by RESET. The FSM register, next-state logic and counter stay in the top.

Test Plan:
- RESET pulse mid-cycle, then release with MemReady = 1, opcode = 0 -> State sequence 0, 1, 6, 7, 0. RegWrite = 1 and RegDst = 1 only in state 7. InstrCount = 1.
- opcode = 35, MemReady = 1 -> states 0, 1, 2, 3, 4. MemRead with IorD = 1 in state 3. MemtoReg = 1 with RegWrite in state 4. 5 cycles total.
- opcode = 43, MemReady held 0 for 3 cycles in MEMWR -> State holds 5 for 4 cycles with MemWrite = 1. No retire until MemReady = 1, then InstrCount increments.
- opcode = 4 with Zero = 1, then Zero = 0 -> PCEn = 1 in BRANCH for the first, 0 for the second. PCSource = 01 in both.
- FETCH with MemReady = 0 for 2 cycles -> IRWrite = 0 and PCWrite = 0 while stalled; both 1 in the cycle MemReady = 1.
- opcode = 63 -> TRAP, Illegal = 1 held for 10 cycles with no strobes asserted. RESET clears Illegal and returns to FETCH. Also preload InstrCount at all-ones via a forced run of 2^CNT_W retires (CNT_W = 4, 16 j instructions) -> wraps to 0.
